// File: rtl/baud_gen_pkg.sv
`default_nettype none
// ============================================================================
// Package  : baud_gen_pkg
// Purpose  : Shared types and constants for the fractional baud generator.
//            Holds the default field widths, divisor typedefs, the run-state
//            enum and the minimum legal integer divisor.
// Revision : 1.0  initial release
// ============================================================================
package baud_gen_pkg;

  localparam int DEF_DIV_W  = 16;
  localparam int DEF_FRAC_W = 4;

  // Smallest integer divisor that still leaves one idle cycle between ticks.
  localparam int MIN_DIV = 2;

  typedef logic [DEF_DIV_W-1:0]  div_int_t;
  typedef logic [DEF_FRAC_W-1:0] div_frac_t;

  localparam int STATE_W = 1;
  typedef enum logic [STATE_W-1:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage : baud_gen_pkg
`default_nettype wire

// File: rtl/frac_accum.sv
`default_nettype none
// ============================================================================
// Module   : frac_accum
// Purpose  : FRAC_W-bit fractional-N phase accumulator. Each step adds the
//            fractional increment; the carry out of the sum is presented
//            combinationally so the caller can stretch the current period.
// Ports    : clk, rst      - clock, synchronous active-high reset
//            i_clr         - zero the accumulator (priority over i_step)
//            i_step        - commit acc + i_frac to the accumulator
//            i_frac        - fractional increment
//            o_carry       - carry of (acc + i_frac), valid every cycle
// Revision : 1.0  initial release
// ============================================================================
module frac_accum #(
  parameter int FRAC_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clr,
  input  logic              i_step,
  input  logic [FRAC_W-1:0] i_frac,
  output logic              o_carry
);

  logic [FRAC_W-1:0] r_acc;
  logic [FRAC_W:0]   w_sum;

  assign w_sum   = {1'b0, r_acc} + {1'b0, i_frac};
  assign o_carry = w_sum[FRAC_W];

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_acc <= '0;
    end else if (i_step) begin
      r_acc <= w_sum[FRAC_W-1:0];
    end
  end

endmodule : frac_accum
`default_nettype wire

// File: rtl/baud_gen_frac.sv
`default_nettype none
// ============================================================================
// Module   : baud_gen_frac
// Purpose  : Runtime-programmable fractional baud tick generator. Emits an
//            oversampled rx_tick and a phase-locked tx_tick (one per
//            OVERSAMPLE rx ticks). Divisor = int + frac/2^FRAC_W clocks per
//            rx tick, averaged via a fractional-N accumulator. Divisor writes
//            made while running are shadowed and applied at a period start.
// Option   : BAUD_GEN_RESYNC_EN - adds rx_resync, which restarts the tick
//            phase (counter, accumulator, oversample count) while running.
// Ports    : clk, rst       - clock, synchronous active-high reset
//            enable         - 1 = RUN, 0 = IDLE (counters held at zero)
//            cfg_div_int    - integer clocks per rx tick (clamped to >= 2)
//            cfg_div_frac   - fractional clocks per rx tick
//            cfg_load       - strobe capturing cfg_div_*
//            rx_resync      - phase restart (option only)
//            cfg_pending    - shadowed divisor waiting for a period start
//            cfg_err        - pulse: loaded integer divisor was clamped
//            rx_tick        - oversampled tick pulse
//            tx_tick        - baud tick pulse, coincident with an rx_tick
// Revision : 1.0  initial release
// ============================================================================
module baud_gen_frac
  import baud_gen_pkg::*;
#(
  parameter int DIV_W        = 16,
  parameter int FRAC_W       = 4,
  parameter int OVERSAMPLE   = 16,
  parameter int RST_DIV_INT  = 326,
  parameter int RST_DIV_FRAC = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [DIV_W-1:0]  cfg_div_int,
  input  logic [FRAC_W-1:0] cfg_div_frac,
  input  logic              cfg_load,
`ifdef BAUD_GEN_RESYNC_EN
  input  logic              rx_resync,
`endif
  output logic              cfg_pending,
  output logic              cfg_err,
  output logic              rx_tick,
  output logic              tx_tick
);

  localparam int                OS_W      = $clog2(OVERSAMPLE);
  localparam logic [OS_W-1:0]   c_OS_LAST = OS_W'(OVERSAMPLE - 1);
  localparam logic [DIV_W-1:0]  c_MIN_DIV = DIV_W'(MIN_DIV);
  localparam logic [DIV_W-1:0]  c_RST_INT = DIV_W'(RST_DIV_INT);
  localparam logic [FRAC_W-1:0] c_RST_FRC = FRAC_W'(RST_DIV_FRAC);
  localparam logic [DIV_W:0]    c_ONE     = (DIV_W+1)'(1);

  state_t            r_state;
  logic [DIV_W-1:0]  r_div_int;
  logic [FRAC_W-1:0] r_div_frac;
  logic [DIV_W-1:0]  r_sh_int;
  logic [FRAC_W-1:0] r_sh_frac;
  logic              r_pending;
  logic              r_err;
  logic              r_start;     // next RUN edge begins a new period
  logic [DIV_W:0]    r_cnt;       // cycles left in the current period
  logic [OS_W-1:0]   r_osc;
  logic              r_rx;
  logic              r_tx;

  logic              w_resync;
  logic              w_clamp;
  logic [DIV_W-1:0]  w_ld_int;
  logic [DIV_W-1:0]  w_sel_int;
  logic [FRAC_W-1:0] w_sel_frac;
  logic              w_carry;
  logic [DIV_W:0]    w_len;
  logic              w_acc_clr;

`ifdef BAUD_GEN_RESYNC_EN
  assign w_resync = rx_resync;
`else
  assign w_resync = 1'b0;
`endif

  assign w_clamp  = (cfg_div_int < c_MIN_DIV);
  assign w_ld_int = w_clamp ? c_MIN_DIV : cfg_div_int;

  // A period start consumes the shadow if one is waiting, so the length of
  // the new period is computed from the value that is about to become active.
  assign w_sel_int  = r_pending ? r_sh_int  : r_div_int;
  assign w_sel_frac = r_pending ? r_sh_frac : r_div_frac;

  // Leaving RUN or resyncing restarts the fractional phase from zero.
  assign w_acc_clr = (r_state != RUN) || !enable || w_resync;

  frac_accum #(
    .FRAC_W (FRAC_W)
  ) u_frac_accum (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (w_acc_clr),
    .i_step  (r_start),
    .i_frac  (w_sel_frac),
    .o_carry (w_carry)
  );

  // One extra bit so div_int = 2^DIV_W-1 plus a carry cannot wrap.
  assign w_len = {1'b0, w_sel_int} + {{DIV_W{1'b0}}, w_carry};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_div_int  <= c_RST_INT;
      r_div_frac <= c_RST_FRC;
      r_sh_int   <= c_RST_INT;
      r_sh_frac  <= c_RST_FRC;
      r_pending  <= 1'b0;
      r_err      <= 1'b0;
      r_start    <= 1'b0;
      r_cnt      <= '0;
      r_osc      <= '0;
      r_rx       <= 1'b0;
      r_tx       <= 1'b0;
    end else begin
      r_rx  <= 1'b0;
      r_tx  <= 1'b0;
      r_err <= cfg_load && w_clamp;

      case (r_state)
        IDLE: begin
          r_cnt   <= '0;
          r_osc   <= '0;
          r_start <= 1'b0;
          // No ticks are running, so a write goes straight to the active set.
          if (cfg_load) begin
            r_div_int  <= w_ld_int;
            r_div_frac <= cfg_div_frac;
          end
          if (enable) begin
            r_state <= RUN;
            r_start <= 1'b1;
          end
        end

        RUN: begin
          if (!enable) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_osc     <= '0;
            r_start   <= 1'b0;
            r_pending <= 1'b0;
            // Ticks stop here, so any waiting divisor can be committed now.
            if (cfg_load) begin
              r_div_int  <= w_ld_int;
              r_div_frac <= cfg_div_frac;
            end else if (r_pending) begin
              r_div_int  <= r_sh_int;
              r_div_frac <= r_sh_frac;
            end
          end else begin
            if (w_resync) begin
              // Suppresses any tick due this edge and restarts the phase.
              r_cnt   <= '0;
              r_osc   <= '0;
              r_start <= 1'b1;
            end else if (r_start) begin
              r_cnt   <= w_len - c_ONE;
              r_start <= 1'b0;
              if (r_pending) begin
                r_div_int  <= r_sh_int;
                r_div_frac <= r_sh_frac;
                r_pending  <= 1'b0;
              end
            end else if (r_cnt == c_ONE) begin
              r_rx    <= 1'b1;
              r_tx    <= (r_osc == c_OS_LAST);
              r_osc   <= (r_osc == c_OS_LAST) ? '0 : r_osc + OS_W'(1);
              r_cnt   <= '0;
              r_start <= 1'b1;
            end else begin
              r_cnt <= r_cnt - c_ONE;
            end

            // Placed last so a write coinciding with a period start lands in
            // the shadow for the following period (last write wins).
            if (cfg_load) begin
              r_sh_int  <= w_ld_int;
              r_sh_frac <= cfg_div_frac;
              r_pending <= 1'b1;
            end
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign cfg_pending = r_pending;
  assign cfg_err     = r_err;
  assign rx_tick     = r_rx;
  assign tx_tick     = r_tx;

endmodule : baud_gen_frac
`default_nettype wire

// File: tb/tb_baud_gen_frac.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_baud_gen_frac
// Purpose  : Self-checking bench for baud_gen_frac. A reference model turns
//            each clock edge's inputs into absolute tick times pushed onto a
//            scoreboard queue; a negedge monitor pops and compares.
// Option   : BAUD_GEN_RESYNC_EN - enables the rx_resync stimulus.
// Revision : 1.0  initial release
// ============================================================================
module tb_baud_gen_frac;

  localparam int DIV_W        = 16;
  localparam int FRAC_W       = 4;
  localparam int OVERSAMPLE   = 16;
  localparam int RST_DIV_INT  = 326;
  localparam int RST_DIV_FRAC = 8;
  localparam int FRAC_MOD     = 2 ** FRAC_W;
`ifdef BAUD_GEN_RESYNC_EN
  localparam bit RESYNC_EN = 1'b1;
`else
  localparam bit RESYNC_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              enable = 1'b0;
  logic              cfg_load = 1'b0;
  logic              rx_resync = 1'b0;
  logic [DIV_W-1:0]  cfg_div_int = '0;
  logic [FRAC_W-1:0] cfg_div_frac = '0;
  logic              cfg_pending, cfg_err, rx_tick, tx_tick;

  always #5 clk = ~clk;

  baud_gen_frac #(
    .DIV_W        (DIV_W),
    .FRAC_W       (FRAC_W),
    .OVERSAMPLE   (OVERSAMPLE),
    .RST_DIV_INT  (RST_DIV_INT),
    .RST_DIV_FRAC (RST_DIV_FRAC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .cfg_div_int  (cfg_div_int),
    .cfg_div_frac (cfg_div_frac),
    .cfg_load     (cfg_load),
`ifdef BAUD_GEN_RESYNC_EN
    .rx_resync    (rx_resync),
`endif
    .cfg_pending  (cfg_pending),
    .cfg_err      (cfg_err),
    .rx_tick      (rx_tick),
    .tx_tick      (tx_tick)
  );

  typedef struct {
    int cyc;
    bit tx;
  } tick_t;

  tick_t exp_q[$];
  int    cyc = 0;
  int    n_chk = 0;
  int    n_fail = 0;
  bit    chk_on = 1'b0;

  // Reference model state (spec-level quantities, absolute edge numbers).
  bit m_run, m_pend, m_err;
  int m_act_int, m_act_frac, m_sh_int, m_sh_frac;
  int m_acc, m_nticks, m_start_at;
  bit cur_en;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at edge %0d", nm, act, exp, cyc);
    end
  endtask

  task automatic drop_from(input int e);
    while (exp_q.size() > 0 && exp_q[$].cyc >= e) void'(exp_q.pop_back());
  endtask

  // Applies the inputs sampled at edge e to the model.
  task automatic model_edge(input int e);
    int  cl, sum, len;
    bit  rs;
    cl    = (int'(cfg_div_int) < 2) ? 2 : int'(cfg_div_int);
    m_err = !rst && cfg_load && (int'(cfg_div_int) < 2);
    rs    = RESYNC_EN && rx_resync;
    if (rst) begin
      m_run = 0; m_pend = 0; m_acc = 0; m_nticks = 0;
      m_act_int = RST_DIV_INT; m_act_frac = RST_DIV_FRAC;
      exp_q.delete();
      return;
    end
    if (!m_run) begin
      if (cfg_load) begin m_act_int = cl; m_act_frac = int'(cfg_div_frac); end
      if (enable) begin
        m_run = 1; m_start_at = e + 1; m_acc = 0; m_nticks = 0;
      end
    end else if (!enable) begin
      m_run = 0; m_acc = 0; m_nticks = 0;
      drop_from(e);
      if (cfg_load) begin
        m_act_int = cl; m_act_frac = int'(cfg_div_frac);
      end else if (m_pend) begin
        m_act_int = m_sh_int; m_act_frac = m_sh_frac;
      end
      m_pend = 0;
    end else begin
      if (rs) begin
        drop_from(e);
        m_start_at = e + 1; m_acc = 0; m_nticks = 0;
      end else if (e == m_start_at) begin
        if (m_pend) begin m_act_int = m_sh_int; m_act_frac = m_sh_frac; m_pend = 0; end
        sum   = m_acc + m_act_frac;
        len   = m_act_int + sum / FRAC_MOD;
        m_acc = sum % FRAC_MOD;
        exp_q.push_back('{cyc: e + len - 1, tx: (m_nticks % OVERSAMPLE) == OVERSAMPLE - 1});
        m_nticks++;
        m_start_at = e + len;
      end
      if (cfg_load) begin m_sh_int = cl; m_sh_frac = int'(cfg_div_frac); m_pend = 1; end
    end
  endtask

  task automatic step(input bit r, input bit en, input bit ld, input int di, input int df, input bit rs);
    @(negedge clk);
    #1;
    rst = r; enable = en; cfg_load = ld; rx_resync = rs;
    cfg_div_int = DIV_W'(di); cfg_div_frac = FRAC_W'(df);
    cur_en = en;
    model_edge(cyc + 1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, cur_en, 1'b0, 0, 0, 1'b0);
  endtask

  task automatic load(input int di, input int df);
    step(1'b0, cur_en, 1'b1, di, df, 1'b0);
  endtask

  // Scoreboard monitor: compares outputs of the last edge against the queue.
  always @(negedge clk) begin
    if (chk_on) begin
      bit exp_now, exp_tx;
      exp_now = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
      exp_tx  = exp_now ? exp_q[0].tx : 1'b0;
      chk("rx_tick", {31'd0, rx_tick}, {31'd0, exp_now});
      chk("tx_tick", {31'd0, tx_tick}, {31'd0, exp_tx});
      chk("cfg_pending", {31'd0, cfg_pending}, {31'd0, m_pend});
      chk("cfg_err", {31'd0, cfg_err}, {31'd0, m_err});
      if (exp_now) void'(exp_q.pop_front());
    end
  end

  initial begin
    cur_en = 1'b0;
    step(1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
    chk_on = 1'b1;
    step(1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
    idle(2);

    // int=4 frac=0: rx every 4, tx every 64.
    load(4, 0);
    step(1'b0, 1'b1, 1'b0, 0, 0, 1'b0);
    idle(140);

    // int=3 frac=8: periods alternate 3/4.
    step(1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
    idle(2);
    load(3, 8);
    step(1'b0, 1'b1, 1'b0, 0, 0, 1'b0);
    idle(120);

    // Back to int=4, then a mid-period switch to 6.
    load(4, 0);
    idle(10);
    idle(2);
    load(6, 0);
    idle(100);

    // Clamp: int=1 -> 2, frac kept.
    load(1, 0);
    idle(40);
    load(0, 3);
    idle(30);

    // Last write wins while pending.
    load(5, 0);
    load(7, 0);
    load(4, 4);
    idle(60);

    // Enable dropped mid-period, then raised.
    idle(2);
    step(1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
    idle(5);
    step(1'b0, 1'b1, 1'b0, 0, 0, 1'b0);
    idle(40);

`ifdef BAUD_GEN_RESYNC_EN
    begin
      bit found;
      load(4, 0);
      idle(20);
      found = 1'b0;
      for (int g = 0; g < 50 && !found; g++) begin
        if (exp_q.size() > 0 && exp_q[0].cyc == cyc + 3) found = 1'b1;
        else idle(1);
      end
      chk("resync window found", {31'd0, found}, 32'd1);
      step(1'b0, 1'b1, 1'b0, 0, 0, 1'b1);
      idle(80);
    end
`endif

    // Reset mid-run with a pending shadow.
    load(9, 0);
    step(1'b1, 1'b1, 1'b0, 0, 0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 0, 0, 1'b0);
    idle(700);

    // Randomised traffic.
    load(3, 0);
    for (int i = 0; i < 3000; i++) begin
      bit en, ld, rs, r;
      en = ($urandom_range(0, 63) == 0) ? !cur_en : cur_en;
      ld = ($urandom_range(0, 15) == 0);
      rs = ($urandom_range(0, 31) == 0);
      r  = ($urandom_range(0, 499) == 0);
      step(r, en, ld, int'($urandom_range(0, 9)), int'($urandom_range(0, FRAC_MOD - 1)), rs);
    end

    step(1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
    idle(3);
    @(negedge clk);
    #2;
    chk("scoreboard drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule : tb_baud_gen_frac
`default_nettype wire
